mms_stream_collector: RTL and testbench

- Upstream front-end for the 4-number max/min selection stage.
- Accepts a serial byte stream on a valid/ready handshake and groups every 4 accepted bytes.
- Reduces each group to its maximum (select=0) or minimum (select=1) on the fly, and presents one registered result per group downstream.
- Turns the combinational 4-input selector function into a throughput-1-byte/cycle streaming block with backpressure.

---
 rtl/mms_pkg.sv | 15 +
 rtl/mms_pick2.sv | 19 +
 rtl/mms_stream_collector.sv | 140 ++++++++++++++
 tb/tb_mms_stream_collector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mms_pkg.sv
// mms_pkg: shared definitions for the max/min stream collector.
//   DATA_W     default number width
//   mms_data_t one unsigned number
//   SEL_MAX    select code for maximum
//   SEL_MIN    select code for minimum
package mms_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] mms_data_t;

   localparam logic SEL_MAX = 1'b0;
   localparam logic SEL_MIN = 1'b1;

endpackage

// File: rtl/mms_pick2.sv
// mms_pick2: two-input strict comparator deciding whether a new number
// displaces the current candidate.
//   cur_val   in   current candidate
//   new_val   in   incoming number
//   sel       in   SEL_MAX / SEL_MIN
//   take_new  out  1 when new_val strictly beats cur_val; ties keep cur_val
module mms_pick2 #(
   parameter int DATA_W = mms_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] cur_val,
   input  logic [DATA_W-1:0] new_val,
   input  logic              sel,
   output logic              take_new
);
   import mms_pkg::*;

   assign take_new = (sel == SEL_MAX) ? (new_val > cur_val) : (new_val < cur_val);

endmodule

// File: rtl/mms_stream_collector.sv
// mms_stream_collector: groups GRP_N accepted numbers from a valid/ready
// stream and reduces each group to its max or min, one registered result
// per group.
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   in_valid    in   upstream number available
//   in_ready    out  block can accept
//   in_data     in   unsigned number
//   in_select   in   0=max, 1=min; taken from the first element of a group
//   out_valid   out  group result pending
//   out_ready   in   downstream accepts
//   out_result  out  group max/min
//   out_select  out  select used for the group
//   out_index   out  position of the winning element (only with MMS_INDEX_EN)
// Optional feature macro: MMS_INDEX_EN adds the out_index port and the index
// tracking registers.
module mms_stream_collector #(
   parameter  int DATA_W = mms_pkg::DATA_W,
   parameter  int GRP_N  = 4,
   localparam int IDX_W  = $clog2(GRP_N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_select,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_select
`ifdef MMS_INDEX_EN
   ,
   output logic [IDX_W-1:0]  out_index
`endif
);
   import mms_pkg::*;

   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              acc_sel_q, acc_sel_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_result_q, out_result_d;
   logic              out_select_q, out_select_d;
`ifdef MMS_INDEX_EN
   logic [IDX_W-1:0]  acc_idx_q, acc_idx_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;
`endif

   logic is_last;
   logic in_xfer;
   logic take_new;

   assign is_last  = (cnt_q == IDX_W'(GRP_N - 1));
   // Only the closing element of a group needs the output register free.
   assign in_ready = !is_last || !out_valid_q || out_ready;
   assign in_xfer  = in_valid && in_ready;

   // Shared by the accumulate step and the final-element result path.
   mms_pick2 #(.DATA_W(DATA_W)) u_pick2 (
      .cur_val  (acc_q),
      .new_val  (in_data),
      .sel      (acc_sel_q),
      .take_new (take_new)
   );

   always_comb begin
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      acc_sel_d    = acc_sel_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_select_d = out_select_q;
`ifdef MMS_INDEX_EN
      acc_idx_d    = acc_idx_q;
      out_index_d  = out_index_q;
`endif
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (in_xfer) begin
         // GRP_N is a power of two, so the increment wraps to 0 after the last element.
         cnt_d = cnt_q + IDX_W'(1);
         if (cnt_q == '0) begin
            acc_d     = in_data;
            acc_sel_d = in_select;
`ifdef MMS_INDEX_EN
            acc_idx_d = '0;
`endif
         end else if (take_new) begin
            acc_d     = in_data;
`ifdef MMS_INDEX_EN
            acc_idx_d = cnt_q;
`endif
         end
         if (is_last) begin
            out_valid_d  = 1'b1;
            out_result_d = take_new ? in_data : acc_q;
            out_select_d = acc_sel_q;
`ifdef MMS_INDEX_EN
            out_index_d  = take_new ? cnt_q : acc_idx_q;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         acc_q        <= '0;
         acc_sel_q    <= SEL_MAX;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_select_q <= SEL_MAX;
`ifdef MMS_INDEX_EN
         acc_idx_q    <= '0;
         out_index_q  <= '0;
`endif
      end else begin
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         acc_sel_q    <= acc_sel_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_select_q <= out_select_d;
`ifdef MMS_INDEX_EN
         acc_idx_q    <= acc_idx_d;
         out_index_q  <= out_index_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_select = out_select_q;
`ifdef MMS_INDEX_EN
   assign out_index  = out_index_q;
`endif

endmodule

// File: tb/tb_mms_stream_collector.sv
// tb_mms_stream_collector: directed bench for mms_stream_collector.
// Index checks are compiled in when MMS_INDEX_EN is defined.
module tb_mms_stream_collector;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_select;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_select;
`ifdef MMS_INDEX_EN
   logic [1:0] out_index;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_first;
   int t_second;
   int n_valid;

   mms_stream_collector #(.DATA_W(8), .GRP_N(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_select  (in_select),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_select (out_select)
`ifdef MMS_INDEX_EN
      ,
      .out_index  (out_index)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one number and hold it until accepted (bounded wait).
   task automatic push(input logic [7:0] d, input logic s);
      int guard;
      guard     = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_select = s;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      if (!in_ready) chk("push_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input int res, input int sel, input int idx);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_result"}, out_result, res);
      chk({tag, "_select"}, out_select, sel);
`ifdef MMS_INDEX_EN
      chk({tag, "_index"}, out_index, idx);
`else
      if (idx < 0) chk({tag, "_index_arg"}, idx, 0);
`endif
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_select = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_select", out_select, 0);
`ifdef MMS_INDEX_EN
      chk("rst_out_index", out_index, 0);
`endif
      tick();
      reset = 1'b0;
      tick();

      // Max group
      push(8'd12, 1'b0); push(8'd200, 1'b0); push(8'd7, 1'b0);
      chk("max_pre_valid", out_valid, 0);
      push(8'd200, 1'b0);
      chk_out("max", 200, 0, 1);
      tick();
      chk("max_drain", out_valid, 0);

      // Back-to-back min then max
      chk("b2b_rdy0", in_ready, 1); push(8'd5, 1'b1);
      chk("b2b_rdy1", in_ready, 1); push(8'd3, 1'b1);
      chk("b2b_rdy2", in_ready, 1); push(8'd3, 1'b1);
      chk("b2b_rdy3", in_ready, 1); push(8'd9, 1'b1);
      t_first = cyc;
      chk_out("min", 3, 1, 1);
      chk("b2b_rdy4", in_ready, 1); push(8'd0, 1'b0);
      chk("b2b_rdy5", in_ready, 1); push(8'd255, 1'b0);
      chk("b2b_rdy6", in_ready, 1); push(8'd1, 1'b0);
      chk("b2b_rdy7", in_ready, 1); push(8'd2, 1'b0);
      t_second = cyc;
      chk_out("b2b_max", 255, 0, 1);
      chk("b2b_spacing", t_second - t_first, 4);
      tick();

      // Select sampled once per group
      push(8'd50, 1'b1); push(8'd10, 1'b0); push(8'd90, 1'b1); push(8'd10, 1'b0);
      chk_out("selonce", 10, 1, 1);
      tick();

      // Backpressure
      push(8'd12, 1'b0); push(8'd200, 1'b0); push(8'd7, 1'b0); push(8'd200, 1'b0);
      chk_out("bp_first", 200, 0, 1);
      out_ready = 1'b0;
      push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0);
      chk_out("bp_hold", 200, 0, 1);
      in_valid = 1'b1; in_data = 8'd4; in_select = 1'b0;
      #1;
      chk("bp_stall", in_ready, 0);
      tick();
      chk("bp_stall2", in_ready, 0);
      chk_out("bp_hold2", 200, 0, 1);
      out_ready = 1'b1;
      #1;
      chk("bp_release", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk_out("bp_new", 4, 0, 3);
      tick();
      chk("bp_drain", out_valid, 0);

      // Reset mid-group
      push(8'd1, 1'b0); push(8'd2, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_ready", in_ready, 1);
      tick();
      reset = 1'b0;
      tick();
      // Reset while a result is pending
      push(8'd9, 1'b1); push(8'd8, 1'b1); push(8'd7, 1'b1); push(8'd6, 1'b1);
      chk_out("pend", 6, 1, 3);
      out_ready = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("rst_pend_valid", out_valid, 0);
      chk("rst_pend_result", out_result, 0);
      chk("rst_pend_select", out_select, 0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("post_rst_valid", out_valid, 0);
      push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0); push(8'd4, 1'b0);
      chk_out("post_rst", 4, 0, 3);
      n_valid = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) n_valid++;
         tick();
      end
      chk("post_rst_count", n_valid, 1);

      // Extremes
      push(8'd0, 1'b1); push(8'd0, 1'b1); push(8'd0, 1'b1); push(8'd0, 1'b1);
      chk_out("zeros", 0, 1, 0);
      push(8'd255, 1'b0); push(8'd255, 1'b0); push(8'd255, 1'b0); push(8'd255, 1'b0);
      chk_out("ones", 255, 0, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
